// File: rtl/mips16_multicycle_core.sv
// Multi-cycle 16-bit MIPS-style core: FETCH/DECODE/EXECUTE/WRITEBACK FSM with a
// req/ack instruction fetch port, so wait-stated memories work unchanged.
module mips16_multicycle_core #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PC_W   = 16,
   parameter int unsigned NREGS  = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic [PC_W-1:0]   pc,
   output logic [15:0]       ir,
   output logic [DATA_W-1:0] alu_out,
   output logic [2:0]        state,
   output logic              halted
);

   typedef enum logic [2:0] {
      StFetch     = 3'd0,
      StDecode    = 3'd1,
      StExecute   = 3'd2,
      StWriteback = 3'd3,
      StHalt      = 3'd4
   } state_e;

   localparam logic [3:0] OpAdd  = 4'h0;
   localparam logic [3:0] OpSub  = 4'h1;
   localparam logic [3:0] OpAnd  = 4'h2;
   localparam logic [3:0] OpOr   = 4'h3;
   localparam logic [3:0] OpNor  = 4'h4;
   localparam logic [3:0] OpNand = 4'h5;
   localparam logic [3:0] OpSlt  = 4'h6;
   localparam logic [3:0] OpAddi = 4'h7;
   localparam logic [3:0] OpBeq  = 4'h8;
   localparam logic [3:0] OpBne  = 4'h9;
   localparam logic [3:0] OpHalt = 4'hf;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic [DATA_W-1:0]   alu_q, alu_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [DATA_W-1:0]   regs_q [NREGS];
   logic [DATA_W-1:0]   regs_d [NREGS];
   logic [DATA_W-1:0]   alu_res;
   logic [PC_W-1:0]     br_off;
   logic [3:0]          op;
   logic [1:0]          rs, rt, rd, dest;
   logic                br_taken;
   logic                fetch_req;

   assign op   = ir_q[15:12];
   assign rs   = ir_q[11:10];
   assign rt   = ir_q[9:8];
   assign rd   = ir_q[7:6];
   assign dest = (op == OpAddi) ? rt : rd;

   // Branch offset is in halfwords, relative to the already-incremented pc.
   assign br_off   = PC_W'($signed(ir_q[7:0])) << 1;
   assign br_taken = (a_q == b_q) == (op == OpBeq);

   always_comb begin
      alu_res = '0;
      case (op)
         OpAdd:        alu_res = a_q + b_q;
         OpSub:        alu_res = a_q - b_q;
         OpAnd:        alu_res = a_q & b_q;
         OpOr:         alu_res = a_q | b_q;
         OpNor:        alu_res = ~(a_q | b_q);
         OpNand:       alu_res = ~(a_q & b_q);
         OpSlt:        alu_res = DATA_W'($signed(a_q) < $signed(b_q));
         OpAddi:       alu_res = a_q + imm_q;
         OpBeq, OpBne: alu_res = a_q - b_q;
         default:      alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      alu_d     = alu_q;
      a_d       = a_q;
      b_d       = b_q;
      imm_d     = imm_q;
      regs_d    = regs_q;
      fetch_req = 1'b0;
      unique case (state_q)
         StFetch: begin
            fetch_req = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + PC_W'(2);
               state_d = StDecode;
            end
         end
         StDecode: begin
            a_d     = regs_q[rs];
            b_d     = regs_q[rt];
            imm_d   = DATA_W'($signed(ir_q[7:0]));
            state_d = StExecute;
         end
         StExecute: begin
            if (op <= OpAddi) begin
               alu_d   = alu_res;
               state_d = StWriteback;
            end else if (op == OpBeq || op == OpBne) begin
               alu_d = alu_res;
               if (br_taken) begin
                  pc_d = pc_q + br_off;
               end
               state_d = StFetch;
            end else if (op == OpHalt) begin
               state_d = StHalt;
            end else begin
               state_d = StFetch;
            end
         end
         StWriteback: begin
            // R0 is never written, so it reads back as zero.
            if (dest != 2'd0) begin
               regs_d[dest] = alu_q;
            end
            state_d = StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
         alu_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         alu_q   <= alu_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // The reset state is FETCH, so the request is gated to stay low during reset.
   assign imem_req  = fetch_req & reset_n;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign alu_out   = alu_q;
   assign state     = state_q;
   assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_mips16_multicycle_core.sv
// Bench for mips16_multicycle_core: directed programs plus random programs checked
// instruction by instruction against an ISA-level reference model.
module tb_mips16_multicycle_core;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req, imem_ack, halted;
   logic [15:0] imem_addr, imem_rdata, pc, ir, alu_out;
   logic [2:0]  state;

   logic        req8, halted8;
   logic [15:0] addr8, rdata8, pc8, ir8;
   logic [7:0]  alu8;
   logic [2:0]  state8;
   logic [15:0] rom8 [4];

   always #5 clock = ~clock;

   mips16_multicycle_core #(.DATA_W(16), .PC_W(16), .NREGS(4)) dut (
      .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .alu_out(alu_out),
      .state(state), .halted(halted)
   );

   // 8-bit datapath instance for the addi wrap case, on a zero-wait ROM.
   mips16_multicycle_core #(.DATA_W(8), .PC_W(16), .NREGS(4)) dut8 (
      .clock(clock), .reset_n(reset_n), .imem_req(req8), .imem_addr(addr8),
      .imem_ack(req8), .imem_rdata(rdata8), .pc(pc8), .ir(ir8), .alu_out(alu8),
      .state(state8), .halted(halted8)
   );
   assign rdata8 = rom8[addr8[2:1]];

   logic [15:0] imem [256];
   int          mem_waits = 0;
   int          wait_cnt = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   logic [15:0] m_r [4];
   logic [15:0] m_pc, m_alu;
   logic        m_halt;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [1:0] rs,
                                         input logic [1:0] rt, input logic [1:0] rd);
      return {op, rs, rt, rd, 6'b0};
   endfunction

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] rs,
                                         input logic [1:0] rt, input logic [7:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Memory: ack after mem_waits request cycles; junk data otherwise; ack offered in reset.
   initial begin
      imem_ack = 1'b0;
      imem_rdata = 16'h0;
      forever begin
         @(posedge clock);
         #2;
         if (!reset_n) begin
            imem_ack = 1'b1;
            imem_rdata = 16'($urandom);
            wait_cnt = 0;
         end else if (imem_req) begin
            if (wait_cnt >= mem_waits) begin
               imem_ack = 1'b1;
               imem_rdata = imem[imem_addr[8:1]];
               wait_cnt = 0;
            end else begin
               imem_ack = 1'b0;
               imem_rdata = 16'($urandom);
               wait_cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
      m_pc = 16'h0;
      m_alu = 16'h0;
      m_halt = 1'b0;
   endtask

   // ISA-level step: architectural effect and expected cycle count of one instruction.
   task automatic model_step(input logic [15:0] ins, output int lat);
      logic [3:0]  op;
      logic [15:0] a, b, imm, res;
      int          d;
      op  = ins[15:12];
      a   = m_r[ins[11:10]];
      b   = m_r[ins[9:8]];
      imm = {{8{ins[7]}}, ins[7:0]};
      m_pc = m_pc + 16'd2;
      lat = mem_waits + 3;
      if (op <= 4'd7) begin
         case (op)
            4'd0: res = a + b;
            4'd1: res = a - b;
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = ~(a | b);
            4'd5: res = ~(a & b);
            4'd6: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: res = a + imm;
         endcase
         d = (op == 4'd7) ? int'(ins[9:8]) : int'(ins[7:6]);
         m_alu = res;
         if (d != 0) m_r[d] = res;
         lat = mem_waits + 4;
      end else if (op == 4'd8 || op == 4'd9) begin
         m_alu = a - b;
         if ((op == 4'd8) == (a == b)) m_pc = m_pc + (imm << 1);
      end else if (op == 4'hf) begin
         m_halt = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("rst_req", imem_req, 0);
      check_eq("rst_pc", pc, 0);
      check_eq("rst_ir", ir, 0);
      check_eq("rst_alu", alu_out, 0);
      check_eq("rst_state", state, 0);
      check_eq("rst_halted", halted, 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      model_reset();
      @(negedge clock);
   endtask

   // Called at the sampling point of an instruction's first FETCH cycle.
   task automatic run_instr(output int n);
      logic [15:0] ins, fa;
      int          lat;
      bit          left, done;
      check_eq("fetch_state", state, 0);
      check_eq("fetch_req", imem_req, 1);
      check_eq("fetch_addr", imem_addr, m_pc);
      fa = imem_addr;
      ins = imem[m_pc[8:1]];
      model_step(ins, lat);
      n = 1;
      left = 0;
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clock);
         if (state == 3'd0 && !left) begin
            n++;
            check_eq("wait_req", imem_req, 1);
            check_eq("wait_addr", imem_addr, fa);
         end else if (state == 3'd0 || state == 3'd4) begin
            done = 1;
         end else begin
            left = 1;
            n++;
         end
      end
      check_eq("latency", n, lat);
      check_eq("pc", pc, m_pc);
      check_eq("alu_out", alu_out, m_alu);
      check_eq("halted", halted, m_halt);
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) imem[i] = 16'hf000;
   endtask

   logic [15:0] prog [9];
   logic [15:0] exp_alu [9];
   int          n;

   initial begin
      rom8[0] = enc_i(4'h7, 2'd0, 2'd1, 8'h7f);
      rom8[1] = enc_i(4'h7, 2'd1, 2'd1, 8'h01);
      rom8[2] = 16'hf000;
      rom8[3] = 16'hf000;

      prog[0] = enc_i(4'h7, 2'd0, 2'd1, 8'd15);
      prog[1] = enc_i(4'h7, 2'd0, 2'd2, 8'd7);
      prog[2] = enc_r(4'h2, 2'd1, 2'd2, 2'd3);
      prog[3] = enc_r(4'h1, 2'd1, 2'd3, 2'd2);
      prog[4] = enc_r(4'h3, 2'd2, 2'd3, 2'd2);
      prog[5] = enc_r(4'h0, 2'd2, 2'd3, 2'd3);
      prog[6] = enc_r(4'h4, 2'd2, 2'd3, 2'd1);
      prog[7] = enc_r(4'h6, 2'd3, 2'd2, 2'd1);
      prog[8] = enc_r(4'h6, 2'd2, 2'd3, 2'd1);
      exp_alu = '{16'd15, 16'd7, 16'd7, 16'd8, 16'd15, 16'd22, 16'hffe0, 16'd0, 16'd1};

      // Reference program, zero-wait and two-wait memory.
      for (int w = 0; w <= 2; w += 2) begin
         mem_waits = w;
         fill_halt();
         for (int i = 0; i < 9; i++) imem[i] = prog[i];
         do_reset();
         for (int i = 0; i < 9; i++) begin
            run_instr(n);
            check_eq("prog_alu", alu_out, exp_alu[i]);
            check_eq("prog_cycles", n, 4 + w);
         end
         check_eq("w8_halted", halted8, 1);
         check_eq("w8_addi_wrap", alu8, 8'h80);
      end

      // Branches: beq taken to 12, bne not taken, beq -1 at pc 0.
      mem_waits = 1;
      fill_halt();
      imem[0] = enc_i(4'h7, 2'd0, 2'd1, 8'd5);
      imem[1] = enc_i(4'h7, 2'd0, 2'd2, 8'd5);
      imem[2] = enc_i(4'h8, 2'd1, 2'd2, 8'd3);
      imem[6] = enc_i(4'h9, 2'd1, 2'd2, 8'd3);
      do_reset();
      for (int i = 0; i < 3; i++) run_instr(n);
      check_eq("beq_target", imem_addr, 16'd12);
      run_instr(n);
      check_eq("bne_fall", imem_addr, 16'd14);
      mem_waits = 0;
      imem[0] = enc_i(4'h8, 2'd0, 2'd0, 8'hff);
      do_reset();
      for (int i = 0; i < 2; i++) begin
         run_instr(n);
         check_eq("beq_self", imem_addr, 16'd0);
         check_eq("beq_cycles", n, 3);
      end

      // Signed slt, R0 writes discarded, then halt.
      fill_halt();
      imem[0] = enc_i(4'h7, 2'd0, 2'd1, 8'hff);
      imem[1] = enc_r(4'h6, 2'd1, 2'd0, 2'd2);
      imem[2] = enc_r(4'h0, 2'd1, 2'd1, 2'd0);
      imem[3] = enc_r(4'h3, 2'd0, 2'd0, 2'd3);
      imem[4] = enc_r(4'h0, 2'd2, 2'd0, 2'd3);
      do_reset();
      run_instr(n);
      run_instr(n);
      check_eq("slt_signed", alu_out, 16'd1);
      run_instr(n);
      run_instr(n);
      check_eq("r0_zero", alu_out, 16'd0);
      run_instr(n);
      check_eq("slt_reg", alu_out, 16'd1);
      run_instr(n);
      for (int i = 0; i < 20; i++) begin
         check_eq("halt_flag", halted, 1);
         check_eq("halt_req", imem_req, 0);
         check_eq("halt_pc", pc, 16'd12);
         @(negedge clock);
      end

      // Reset during WRITEBACK abandons the write and restarts at 0.
      fill_halt();
      imem[0] = enc_i(4'h7, 2'd0, 2'd1, 8'd9);
      do_reset();
      for (int k = 0; k < 10 && state != 3'd3; k++) @(negedge clock);
      check_eq("wb_reached", state, 3);
      #1 reset_n = 1'b0;
      #1;
      check_eq("wb_rst_state", state, 0);
      check_eq("wb_rst_pc", pc, 0);
      imem[0] = enc_r(4'h3, 2'd1, 2'd1, 2'd2);
      @(posedge clock);
      #1 reset_n = 1'b1;
      model_reset();
      @(negedge clock);
      run_instr(n);
      check_eq("wb_no_write", alu_out, 16'd0);

      // Random programs at random wait counts.
      for (int s = 0; s < 4; s++) begin
         mem_waits = $urandom_range(0, 3);
         for (int i = 0; i < 256; i++) begin
            imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
         end
         do_reset();
         repeat (50) run_instr(n);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
